pc_sequencer: RTL and testbench

Fetch/execute sequencer for the KGPRISC program counter. Each cycle it computes the value presented on the ProgramCounter `Ip` input, so the PC holds, advances, branches or returns to the reset vector. It also runs the instruction-memory request/acknowledge handshake and waits for the datapath to retire each instruction. It stops in a halt state on a halt request or a fetch fault.

---
 rtl/pc_sequencer.sv | 140 ++++++++++++++
 tb/tb_pc_sequencer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/execute sequencer that computes the program counter's
// next value and runs the instruction-memory request/acknowledge handshake.
// Ports: Clk, Reset (async active-low), Start, CurPc (PC state in),
//   NextPc (PC load value), ImemReq/ImemAddr/ImemAck (fetch handshake),
//   InstrValid (first EXEC cycle pulse), ExecDone/BranchTaken/BranchTarget/
//   HaltReq (retire info), Halted, Fault, SeqState (IDLE=0 FETCH=1 EXEC=2
//   HALT=3).
// Optional feature macro: PC_ALIGN_CHECK_EN (faults on misaligned branch).
module pc_sequencer #(
   parameter int               WIDTH         = 32,
   parameter int               PC_STEP       = 4,
   parameter logic [WIDTH-1:0] RESET_VECTOR  = '0,
   parameter int               FETCH_TIMEOUT = 15
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [WIDTH-1:0] CurPc,
   output logic [WIDTH-1:0] NextPc,
   output logic             ImemReq,
   output logic [WIDTH-1:0] ImemAddr,
   input  logic             ImemAck,
   output logic             InstrValid,
   input  logic             ExecDone,
   input  logic             BranchTaken,
   input  logic [WIDTH-1:0] BranchTarget,
   input  logic             HaltReq,
   output logic             Halted,
   output logic             Fault,
   output logic [1:0]       SeqState
);

   // Counter only has to hold 0..FETCH_TIMEOUT-1.
   localparam int CW =
      (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
   localparam bit TO_EN = (FETCH_TIMEOUT > 0);
   localparam logic [CW-1:0] CNT_LAST =
      TO_EN ? CW'(FETCH_TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic [CW-1:0]   cnt;
   logic            timeout_hit;
   logic            misaligned;
   logic            go_fault;
   logic [WIDTH-1:0] next_pc;
   logic            instr_valid;
   logic            halted;
   logic            fault;

`ifdef PC_ALIGN_CHECK_EN
   assign misaligned = |BranchTarget[1:0];
`else
   assign misaligned = 1'b0;
`endif

   // Last allowed FETCH cycle without an ack; an ack in it still wins.
   assign timeout_hit = TO_EN && (cnt == CNT_LAST);

   always_comb begin
      state_nx = state;
      next_pc  = CurPc;
      go_fault = 1'b0;
      unique case (state)
         S_IDLE: begin
            next_pc = RESET_VECTOR;
            if (Start) state_nx = S_FETCH;
         end
         S_FETCH: begin
            if (ImemAck) begin
               state_nx = S_EXEC;
            end else if (timeout_hit) begin
               state_nx = S_HALT;
               go_fault = 1'b1;
            end
         end
         S_EXEC: begin
            if (ExecDone) begin
               if (HaltReq) begin
                  state_nx = S_HALT;
               end else if (BranchTaken && misaligned) begin
                  state_nx = S_HALT;
                  go_fault = 1'b1;
               end else if (BranchTaken) begin
                  next_pc  = BranchTarget;
                  state_nx = S_FETCH;
               end else begin
                  next_pc  = CurPc + WIDTH'(PC_STEP);
                  state_nx = S_FETCH;
               end
            end
         end
         S_HALT: begin
            if (Start) state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state       <= S_IDLE;
         cnt         <= '0;
         instr_valid <= 1'b0;
         halted      <= 1'b0;
         fault       <= 1'b0;
      end else begin
         state       <= state_nx;
         instr_valid <= (state == S_FETCH) && ImemAck;
         halted      <= (state_nx == S_HALT);
         // Held at zero outside FETCH, so every FETCH entry starts fresh.
         if (state != S_FETCH)
            cnt <= '0;
         else if (!ImemAck && TO_EN)
            cnt <= cnt + CW'(1);
         if (go_fault)
            fault <= 1'b1;
         else if ((state == S_HALT) && Start)
            fault <= 1'b0;
      end
   end

   assign NextPc     = next_pc;
   assign ImemReq    = (state == S_FETCH);
   assign ImemAddr   = CurPc;
   assign InstrValid = instr_valid;
   assign Halted     = halted;
   assign Fault      = fault;
   assign SeqState   = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: self-checking bench for pc_sequencer with a modelled
// program counter register and a transaction-level PC reference.
module tb_pc_sequencer;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         ack = 1'b0;
   logic         done = 1'b0;
   logic         br = 1'b0;
   logic         hreq = 1'b0;
   logic [W-1:0] target = '0;
   logic [W-1:0] pc = '0;
   logic [W-1:0] next_pc;
   logic [W-1:0] addr;
   logic         req;
   logic         ivalid;
   logic         halted;
   logic         fault;
   logic [1:0]   sstate;
   logic         pc_ovr = 1'b0;
   logic [W-1:0] pc_ovr_val = '0;
   logic [W-1:0] rand_base = '0;
   int passed = 0;
   int total = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   // ProgramCounter: loads NextPc every edge; override models an external
   // PC value for boundary scenarios.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      pc  <= pc_ovr ? pc_ovr_val : next_pc;
   end

   pc_sequencer #(
      .WIDTH(W),
      .PC_STEP(4),
      .RESET_VECTOR(32'h0),
      .FETCH_TIMEOUT(15)
   ) dut (
      .Clk(clk),
      .Reset(rst_n),
      .Start(start),
      .CurPc(pc),
      .NextPc(next_pc),
      .ImemReq(req),
      .ImemAddr(addr),
      .ImemAck(ack),
      .InstrValid(ivalid),
      .ExecDone(done),
      .BranchTaken(br),
      .BranchTarget(target),
      .HaltReq(hreq),
      .Halted(halted),
      .Fault(fault),
      .SeqState(sstate)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      total++;
      if ({sstate, req, halted, fault, ivalid} !== 6'b0)
         $display("FAIL por_state got st=%0d req=%0b h=%0b f=%0b iv=%0b want all 0",
                  sstate, req, halted, fault, ivalid);
      else passed++;
      rst_n = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      pc_ovr = 1'b1;
      pc_ovr_val = 32'h40;
      step();
      pc_ovr = 1'b0;
      total++;
      if (sstate !== 2'd1 || addr !== 32'h40)
         $display("FAIL pre_reset_fetch got st=%0d addr=%h want 1/00000040",
                  sstate, addr);
      else passed++;
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (sstate !== 2'd0 || req !== 1'b0)
         $display("FAIL mid_fetch_reset got st=%0d req=%0b want 0/0", sstate, req);
      else passed++;
      total++;
      if (halted !== 1'b0 || fault !== 1'b0)
         $display("FAIL mid_fetch_reset_flags got h=%0b f=%0b want 0/0",
                  halted, fault);
      else passed++;
      step();
      rst_n = 1'b1;
      #1;
      total++;
      if (next_pc !== 32'h0)
         $display("FAIL reset_nextpc got %h want 00000000", next_pc);
      else passed++;
   endtask

   task automatic test_sequential();
      int last;
      last = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (req !== 1'b1 || addr !== W'(i * 4))
            $display("FAIL seq_addr%0d got req=%0b addr=%h want 1/%h",
                     i, req, addr, W'(i * 4));
         else passed++;
         ack = 1'b1;
         step();
         ack = 1'b0;
         total++;
         if (ivalid !== 1'b1)
            $display("FAIL seq_ivalid%0d got %0b want 1", i, ivalid);
         else passed++;
         if (i > 0) begin
            total++;
            if (cyc - last != 2)
               $display("FAIL seq_period%0d got %0d want 2", i, cyc - last);
            else passed++;
         end
         last = cyc;
         done = 1'b1;
         step();
         done = 1'b0;
         total++;
         if (ivalid !== 1'b0)
            $display("FAIL seq_ivalid_drop%0d got %0b want 0", i, ivalid);
         else passed++;
      end
   endtask

   task automatic test_branch();
      ack = 1'b1;
      step();
      ack = 1'b0;
      done = 1'b1;
      br = 1'b1;
      target = 32'h100;
      #1;
      total++;
      if (next_pc !== 32'h100)
         $display("FAIL branch_nextpc got %h want 00000100", next_pc);
      else passed++;
      step();
      done = 1'b0;
      br = 1'b0;
      total++;
      if (sstate !== 2'd1 || addr !== 32'h100)
         $display("FAIL branch_fetch got st=%0d addr=%h want 1/00000100",
                  sstate, addr);
      else passed++;
      ack = 1'b1;
      pc_ovr = 1'b1;
      pc_ovr_val = 32'hFFFF_FFFC;
      step();
      ack = 1'b0;
      pc_ovr = 1'b0;
      done = 1'b1;
      #1;
      total++;
      if (next_pc !== 32'h0)
         $display("FAIL wrap_nextpc got %h want 00000000", next_pc);
      else passed++;
      step();
      done = 1'b0;
      total++;
      if (sstate !== 2'd1 || addr !== 32'h0)
         $display("FAIL wrap_fetch got st=%0d addr=%h want 1/00000000",
                  sstate, addr);
      else passed++;
   endtask

   task automatic test_halt();
      ack = 1'b1;
      pc_ovr = 1'b1;
      pc_ovr_val = 32'h20;
      step();
      ack = 1'b0;
      pc_ovr = 1'b0;
      done = 1'b1;
      hreq = 1'b1;
      br = 1'b1;
      target = 32'h100;
      #1;
      total++;
      if (next_pc !== 32'h20)
         $display("FAIL halt_nextpc got %h want 00000020", next_pc);
      else passed++;
      step();
      done = 1'b0;
      hreq = 1'b0;
      br = 1'b0;
      total++;
      if (sstate !== 2'd3 || halted !== 1'b1 || fault !== 1'b0)
         $display("FAIL halt_state got st=%0d h=%0b f=%0b want 3/1/0",
                  sstate, halted, fault);
      else passed++;
      step();
      step();
      total++;
      if (addr !== 32'h20 || halted !== 1'b1 || req !== 1'b0)
         $display("FAIL halt_hold got addr=%h h=%0b req=%0b want 00000020/1/0",
                  addr, halted, req);
      else passed++;
      start = 1'b1;
      step();
      total++;
      if (sstate !== 2'd0 || halted !== 1'b0)
         $display("FAIL halt_exit got st=%0d h=%0b want 0/0", sstate, halted);
      else passed++;
      step();
      start = 1'b0;
      total++;
      if (sstate !== 2'd1 || addr !== 32'h0)
         $display("FAIL restart_fetch got st=%0d addr=%h want 1/00000000",
                  sstate, addr);
      else passed++;
   endtask

   task automatic test_timeout();
      for (int k = 1; k < 15; k++) begin
         step();
         total++;
         if (sstate !== 2'd1)
            $display("FAIL timeout_wait%0d got st=%0d want 1", k, sstate);
         else passed++;
      end
      step();
      total++;
      if (sstate !== 2'd3 || fault !== 1'b1 || halted !== 1'b1)
         $display("FAIL timeout_fault got st=%0d f=%0b h=%0b want 3/1/1",
                  sstate, fault, halted);
      else passed++;
      start = 1'b1;
      step();
      total++;
      if (sstate !== 2'd0 || fault !== 1'b0)
         $display("FAIL fault_clear got st=%0d f=%0b want 0/0", sstate, fault);
      else passed++;
      step();
      start = 1'b0;
      repeat (14) step();
      ack = 1'b1;
      step();
      ack = 1'b0;
      total++;
      if (sstate !== 2'd2 || fault !== 1'b0 || ivalid !== 1'b1)
         $display("FAIL ack_at_limit got st=%0d f=%0b iv=%0b want 2/0/1",
                  sstate, fault, ivalid);
      else passed++;
      done = 1'b1;
      step();
      done = 1'b0;
   endtask

   task automatic test_align();
      ack = 1'b1;
      step();
      ack = 1'b0;
      done = 1'b1;
      br = 1'b1;
      target = 32'h102;
`ifdef PC_ALIGN_CHECK_EN
      #1;
      total++;
      if (next_pc !== 32'h4)
         $display("FAIL align_nextpc got %h want 00000004", next_pc);
      else passed++;
      step();
      done = 1'b0;
      br = 1'b0;
      total++;
      if (sstate !== 2'd3 || fault !== 1'b1 || addr !== 32'h4)
         $display("FAIL align_fault got st=%0d f=%0b addr=%h want 3/1/00000004",
                  sstate, fault, addr);
      else passed++;
      start = 1'b1;
      step();
      step();
      start = 1'b0;
      rand_base = 32'h0;
`else
      step();
      done = 1'b0;
      br = 1'b0;
      total++;
      if (sstate !== 2'd1 || addr !== 32'h102 || fault !== 1'b0)
         $display("FAIL align_load got st=%0d addr=%h f=%0b want 1/00000102/0",
                  sstate, addr, fault);
      else passed++;
      rand_base = 32'h102;
`endif
   endtask

   // Reference: each retired instruction moves the PC to the branch target
   // or to PC+4; fetch/exec waits are arbitrary and must not disturb it.
   task automatic test_random(input logic [W-1:0] base);
      logic [W-1:0] exp;
      logic [W-1:0] exp_n;
      logic [W-1:0] t;
      int d;
      exp = base;
      for (int i = 0; i < 40; i++) begin
         d = $urandom_range(0, 5);
         repeat (d) begin
            ack = 1'b0;
            done = 1'($urandom);
            start = 1'($urandom);
            #1;
            total++;
            if (sstate !== 2'd1 || addr !== exp || ivalid !== 1'b0)
               $display("FAIL rnd_fetch_wait%0d got st=%0d addr=%h iv=%0b want 1/%h/0",
                        i, sstate, addr, ivalid, exp);
            else passed++;
            step();
         end
         ack = 1'b1;
         done = 1'($urandom);
         #1;
         total++;
         if (req !== 1'b1 || addr !== exp)
            $display("FAIL rnd_fetch%0d got req=%0b addr=%h want 1/%h",
                     i, req, addr, exp);
         else passed++;
         step();
         ack = 1'($urandom);
         done = 1'b0;
         total++;
         if (ivalid !== 1'b1 || sstate !== 2'd2)
            $display("FAIL rnd_exec%0d got iv=%0b st=%0d want 1/2",
                     i, ivalid, sstate);
         else passed++;
         d = $urandom_range(0, 3);
         repeat (d) begin
            done = 1'b0;
            br = 1'($urandom);
            hreq = 1'($urandom);
            target = $urandom;
            start = 1'($urandom);
            #1;
            total++;
            if (next_pc !== exp)
               $display("FAIL rnd_exec_hold%0d got %h want %h", i, next_pc, exp);
            else passed++;
            step();
         end
         t = $urandom;
         t[1:0] = 2'b00;
         done = 1'b1;
         hreq = 1'b0;
         br = 1'($urandom);
         target = t;
         start = 1'($urandom);
         exp_n = br ? t : exp + 32'd4;
         #1;
         total++;
         if (next_pc !== exp_n)
            $display("FAIL rnd_redirect%0d got %h want %h", i, next_pc, exp_n);
         else passed++;
         step();
         exp = exp_n;
         done = 1'b0;
         br = 1'b0;
         start = 1'b0;
         ack = 1'b0;
         total++;
         if (sstate !== 2'd1 || ivalid !== 1'b0)
            $display("FAIL rnd_refetch%0d got st=%0d iv=%0b want 1/0",
                     i, sstate, ivalid);
         else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_branch();
      test_halt();
      test_timeout();
      test_align();
      test_random(rand_base);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
